// File: rtl/tdm_demux.sv
// TDM serial-to-parallel demultiplexer with frame-alignment error detection.
// Optional even-parity slot per frame is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
    parameter int N_CH  = 7,
    parameter int SEL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    input  logic              frame_start,
    output logic [N_CH-1:0]   out,
    output logic              out_valid,
    output logic [SEL_W-1:0]  sel,
    output logic              frame_err,
    output logic              parity_err
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

    state_t            state, state_d;
    logic [SEL_W-1:0]  sel_r, sel_d;
    logic [N_CH-1:0]   shadow, shadow_d;
    logic [N_CH-1:0]   merged;
    logic [N_CH-1:0]   out_r, out_d;
    logic              out_valid_r, out_valid_d;
    logic              frame_err_r, frame_err_d;

`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [SEL_W-1:0] PAR_SLOT = SEL_W'(N_CH);

    logic parity_err_r, parity_err_d;

    function automatic logic even_parity(input logic [N_CH-1:0] v);
        return ^v;
    endfunction
`endif

    // Shadow word with the current slot bit already written at position sel.
    always_comb begin
        merged = shadow;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_r == SEL_W'(i)) begin
                merged[i] = din;
            end
        end
    end

    always_comb begin
        state_d     = state;
        sel_d       = sel_r;
        shadow_d    = shadow;
        out_d       = out_r;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (state)
            HUNT: begin
                // Bits without a marker are dropped while searching for alignment.
                if (din_valid && frame_start) begin
                    shadow_d[0] = din;
                    sel_d       = SEL_W'(1);
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (din_valid) begin
                    if (frame_start) begin
                        // Premature marker: abandon the partial frame and restart at slot 0.
                        frame_err_d = 1'b1;
                        shadow_d[0] = din;
                        sel_d       = SEL_W'(1);
                    end else if (sel_r < LAST_SLOT) begin
                        shadow_d = merged;
                        sel_d    = sel_r + SEL_W'(1);
`ifdef TDM_DEMUX_PARITY_EN
                    end else if (sel_r == LAST_SLOT) begin
                        shadow_d = merged;
                        sel_d    = PAR_SLOT;
                    end else begin
                        if (din == even_parity(shadow)) begin
                            out_d       = shadow;
                            out_valid_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
                        sel_d   = '0;
                        state_d = HUNT;
                    end
`else
                    end else begin
                        shadow_d    = merged;
                        out_d       = merged;
                        out_valid_d = 1'b1;
                        sel_d       = '0;
                        state_d     = HUNT;
                    end
`endif
                end
            end
            default: begin
                state_d = HUNT;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            sel_r       <= '0;
            shadow      <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state       <= state_d;
            sel_r       <= sel_d;
            shadow      <= shadow_d;
            out_r       <= out_d;
            out_valid_r <= out_valid_d;
            frame_err_r <= frame_err_d;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= parity_err_d;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign sel       = sel_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed scoreboard bench for tdm_demux (N_CH=7, SEL_W=3).
// Expected frames are queued as they are driven and popped on each out_valid.
module tb_tdm_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       frame_start;
    logic [6:0] out;
    logic       out_valid;
    logic [2:0] sel;
    logic       frame_err;
    logic       parity_err;

    int total = 0;
    int bad   = 0;
    int nvalid = 0;
    int nferr  = 0;
    int nperr  = 0;
    logic [6:0] expq[$];

    tdm_demux #(.N_CH(7), .SEL_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .frame_start(frame_start),
        .out(out),
        .out_valid(out_valid),
        .sel(sel),
        .frame_err(frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop on out_valid, pulse counting.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                nvalid++;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $error("FAIL unexpected_out_valid got=%b exp=none", out);
                end else begin
                    logic [6:0] e;
                    e = expq.pop_front();
                    assert (out === e) else begin
                        bad++;
                        $error("FAIL frame_out got=%b exp=%b", out, e);
                    end
                end
                total++;
                assert (frame_err === 1'b0) else begin
                    bad++;
                    $error("FAIL err_with_valid got=%b exp=0", frame_err);
                end
            end
            if (frame_err)  nferr++;
            if (parity_err) nperr++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic slot(input logic d, input logic fs);
        din_valid   = 1'b1;
        din         = d;
        frame_start = fs;
        @(posedge clk);
        #1;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        din         = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] bits, input int gaps, input logic expect_ok);
        if (expect_ok) expq.push_back(bits);
        for (int i = 0; i < 7; i++) begin
            slot(bits[i], i == 0);
            if (gaps != 0 && i < 6) idle(int'($urandom_range(1, 3)));
        end
`ifdef TDM_DEMUX_PARITY_EN
        if (gaps != 0) idle(int'($urandom_range(1, 3)));
        slot(^bits, 1'b0);
`endif
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic send_bad_parity(input logic [6:0] bits);
        for (int i = 0; i < 7; i++) slot(bits[i], i == 0);
        slot(~(^bits), 1'b0);
    endtask
`endif

    initial begin
        int v0, f0;
        rst = 1'b1;
        din = 1'b0;
        din_valid = 1'b0;
        frame_start = 1'b0;
        idle(2);
        chk("rst_out", out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_parity_err", parity_err, 0);
        rst = 1'b0;
        idle(1);

        // Single continuous frame
        v0 = nvalid; f0 = nferr;
        slot(1'b1, 1'b1);
        chk("sel_after_slot0", sel, 1);
        expq.push_back(7'b1001101);
        slot(1'b0, 1'b0); slot(1'b1, 1'b0); slot(1'b1, 1'b0);
        slot(1'b0, 1'b0); slot(1'b0, 1'b0); slot(1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        chk("sel_parity_wait", sel, 7);
        slot(1'b0, 1'b0);
`endif
        chk("latency_out_valid", out_valid, 1);
        chk("latency_out", out, 7'b1001101);
        chk("sel_after_frame", sel, 0);
        idle(1);
        chk("out_valid_one_cycle", out_valid, 0);
        chk("out_hold", out, 7'b1001101);
        chk("single_nvalid", nvalid - v0, 1);
        chk("single_nferr", nferr - f0, 0);

        // Mid-frame reset with rst overriding active inputs
        slot(1'b1, 1'b1); slot(1'b1, 1'b0); slot(1'b0, 1'b0); slot(1'b1, 1'b0);
        rst = 1'b1;
        din_valid = 1'b1; frame_start = 1'b1; din = 1'b1;
        idle(2);
        din_valid = 1'b0; frame_start = 1'b0; din = 1'b0;
        chk("midrst_out", out, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sel", sel, 0);
        chk("midrst_frame_err", frame_err, 0);
        rst = 1'b0;
        idle(1);
        v0 = nvalid;
        send_frame(7'b1001101, 0, 1'b1);
        idle(1);
        chk("post_rst_nvalid", nvalid - v0, 1);

        // Gapped frame
        v0 = nvalid; f0 = nferr;
        send_frame(7'b1001101, 1, 1'b1);
        idle(2);
        chk("gap_nvalid", nvalid - v0, 1);
        chk("gap_nferr", nferr - f0, 0);

        // Unaligned bits discarded in HUNT
        v0 = nvalid; f0 = nferr;
        slot(1'b1, 1'b0); slot(1'b1, 1'b0); slot(1'b0, 1'b0);
        chk("hunt_sel", sel, 0);
        send_frame(7'b1111111, 0, 1'b1);
        idle(1);
        chk("hunt_out", out, 7'b1111111);
        chk("hunt_nvalid", nvalid - v0, 1);
        chk("hunt_nferr", nferr - f0, 0);

        // Premature frame marker
        v0 = nvalid; f0 = nferr;
        slot(1'b1, 1'b1); slot(1'b0, 1'b0); slot(1'b0, 1'b0); slot(1'b1, 1'b0);
        send_frame(7'b0101010, 0, 1'b1);
        idle(1);
        chk("premature_out", out, 7'b0101010);
        chk("premature_nvalid", nvalid - v0, 1);
        chk("premature_nferr", nferr - f0, 1);

        // Back-to-back frames, no bubble
        v0 = nvalid; f0 = nferr;
        send_frame(7'b0110011, 0, 1'b1);
        send_frame(7'b1010110, 0, 1'b1);
        idle(1);
        chk("b2b_out", out, 7'b1010110);
        chk("b2b_nvalid", nvalid - v0, 2);
        chk("b2b_nferr", nferr - f0, 0);

`ifdef TDM_DEMUX_PARITY_EN
        // Parity mismatch keeps prior out
        v0 = nvalid; f0 = nperr;
        send_frame(7'b1001101, 0, 1'b1);
        idle(1);
        chk("par_ok_nvalid", nvalid - v0, 1);
        send_bad_parity(7'b1001101);
        chk("par_err_pulse", parity_err, 1);
        chk("par_err_sel", sel, 0);
        idle(1);
        chk("par_err_one_cycle", parity_err, 0);
        chk("par_err_out_kept", out, 7'b1001101);
        chk("par_err_nvalid", nvalid - v0, 1);
        chk("par_err_nperr", nperr - f0, 1);
        // Marker on the parity slot is an alignment error
        f0 = nferr; v0 = nvalid;
        for (int i = 0; i < 7; i++) slot(1'b1, i == 0);
        send_frame(7'b0011100, 0, 1'b1);
        idle(1);
        chk("par_marker_nferr", nferr - f0, 1);
        chk("par_marker_nvalid", nvalid - v0, 1);
`else
        chk("parity_err_tied", parity_err, 0);
        chk("nperr_zero", nperr, 0);
`endif

        idle(2);
        chk("scoreboard_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
